// File: rtl/awb_gain_est_if.sv
// Pixel-tap and gain-publish bundle between the Bayer pixel source, the AWB
// estimator and the colour-correction stage that consumes the gains.
interface awb_gain_est_if;
  logic        clken;
  logic [7:0]  din;
  logic [3:0]  bayer_state_start;
  logic [10:0] h_active_in;
  logic [10:0] v_active_in;
  logic        awb_en;
  logic [7:0]  r_gain_out;
  logic [7:0]  g_gain_out;
  logic [7:0]  b_gain_out;
  logic        gain_valid;
  logic        busy;

  // Source side: drives the pixel stream and frame controls, receives gains.
  modport master (
    output clken, din, bayer_state_start, h_active_in, v_active_in, awb_en,
    input  r_gain_out, g_gain_out, b_gain_out, gain_valid, busy
  );

  // Estimator side.
  modport slave (
    input  clken, din, bayer_state_start, h_active_in, v_active_in, awb_en,
    output r_gain_out, g_gain_out, b_gain_out, gain_valid, busy
  );
endinterface

// File: rtl/awb_gain_est.sv
// Gray-world AWB estimator: per-frame R/G/B sums, then two sequential restoring
// divisions produce 1.7 fixed-point red/blue gains relative to green.
module awb_gain_est #(
  parameter int ACC_W    = 30,
  parameter int DIV_BITS = 9
) (
  input logic          clk,
  input logic          rst,
  awb_gain_est_if.slave bus
);

  // Wide enough for both the dividend (sum<<6) and the divisor shifted by DIV_BITS.
  localparam int W      = ACC_W + DIV_BITS + 1;
  localparam int N_SHIFT = 6;
  localparam logic [3:0] CNT_INIT = 4'(DIV_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    DIV_R  = 3'd2,
    DIV_B  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [10:0]          h_cnt_q, h_cnt_d;
  logic [10:0]          v_cnt_q, v_cnt_d;
  logic [ACC_W-1:0]     r_sum_q, r_sum_d, g_sum_q, g_sum_d, b_sum_q, b_sum_d;
  logic [ACC_W-1:0]     r_snap_q, r_snap_d, g_snap_q, g_snap_d, b_snap_q, b_snap_d;
  logic [W-1:0]         n_q, n_d;
  logic [W-1:0]         rem_q, rem_d;
  logic [W-1:0]         dsh_q, dsh_d;
  logic [DIV_BITS-1:0]  quot_q, quot_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic [7:0]           r_res_q, r_res_d;
  logic [7:0]           b_res_q, b_res_d;
  logic [7:0]           r_gain_q, r_gain_d;
  logic [7:0]           b_gain_q, b_gain_d;
  logic                 gain_valid_q, gain_valid_d;
  logic                 busy_q, busy_d;

  logic                 h_last_s, v_last_s, frame_end_s;
  logic [3:0]           colour_s;
  logic [ACC_W-1:0]     r_add_s, g_add_s, b_add_s;
  logic [ACC_W-1:0]     r_next_s, g_next_s, b_next_s;
  logic [W-1:0]         n_new_s, rem_sub_s;
  logic                 rem_ge_s;
  logic [DIV_BITS-1:0]  quot_next_s;

  // Colour of the current site: odd column swaps within a row pair, odd row swaps rows.
  function automatic logic [3:0] pixel_colour(input logic [3:0] start,
                                              input logic odd_col,
                                              input logic odd_row);
    logic [3:0] c;
    case (start)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: c = start;
      default:                            c = 4'b0001;
    endcase
    if (odd_col) c = {c[2], c[3], c[0], c[1]};
    else         c = c;
    if (odd_row) c = {c[1], c[0], c[3], c[2]};
    else         c = c;
    return c;
  endfunction

  function automatic logic [7:0] clamp_gain(input logic zero,
                                            input logic ovf,
                                            input logic [DIV_BITS-1:0] q);
    logic [7:0] g;
    if (zero)                              g = 8'h80;
    else if (ovf || (q > DIV_BITS'(8'hFF))) g = 8'hFF;
    else                                   g = q[7:0];
    return g;
  endfunction

  assign h_last_s    = (h_cnt_q == (bus.h_active_in - 11'd1));
  assign v_last_s    = (v_cnt_q == (bus.v_active_in - 11'd1));
  assign frame_end_s = bus.clken && h_last_s && v_last_s;
  assign colour_s    = pixel_colour(bus.bayer_state_start, h_cnt_q[0], v_cnt_q[0]);

  assign r_add_s  = colour_s[2] ? ACC_W'(bus.din) : '0;
  assign g_add_s  = (colour_s[0] || colour_s[3]) ? ACC_W'(bus.din) : '0;
  assign b_add_s  = colour_s[1] ? ACC_W'(bus.din) : '0;
  assign r_next_s = r_sum_q + r_add_s;
  assign g_next_s = g_sum_q + g_add_s;
  assign b_next_s = b_sum_q + b_add_s;

  // Gsum/2 * 128: two green sites per red/blue site.
  assign n_new_s     = W'(g_snap_q) << N_SHIFT;
  assign rem_ge_s    = (rem_q >= dsh_q);
  assign rem_sub_s   = rem_q - dsh_q;
  assign quot_next_s = {quot_q[DIV_BITS-2:0], rem_ge_s};

  // Next-state logic for the counters, accumulators and division FSM.
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    r_sum_d      = r_sum_q;
    g_sum_d      = g_sum_q;
    b_sum_d      = b_sum_q;
    r_snap_d     = r_snap_q;
    g_snap_d     = g_snap_q;
    b_snap_d     = b_snap_q;
    n_d          = n_q;
    rem_d        = rem_q;
    dsh_d        = dsh_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    r_res_d      = r_res_q;
    b_res_d      = b_res_q;
    r_gain_d     = r_gain_q;
    b_gain_d     = b_gain_q;
    gain_valid_d = 1'b0;

    if (bus.clken) begin
      if (h_last_s) begin
        h_cnt_d = 11'd0;
        if (v_last_s) v_cnt_d = 11'd0;
        else          v_cnt_d = v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end

      // A frame end while busy still restarts the sums but drops the snapshot.
      if (frame_end_s) begin
        r_sum_d = '0;
        g_sum_d = '0;
        b_sum_d = '0;
        if (state_q == IDLE) begin
          r_snap_d = r_next_s;
          g_snap_d = g_next_s;
          b_snap_d = b_next_s;
        end else begin
          r_snap_d = r_snap_q;
        end
      end else begin
        r_sum_d = r_next_s;
        g_sum_d = g_next_s;
        b_sum_d = b_next_s;
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_end_s) state_d = LATCH;
        else             state_d = IDLE;
      end
      LATCH: begin
        n_d     = n_new_s;
        rem_d   = n_new_s;
        dsh_d   = W'(r_snap_q) << (DIV_BITS - 1);
        ovf_d   = n_new_s >= (W'(r_snap_q) << DIV_BITS);
        zero_d  = (r_snap_q == '0);
        quot_d  = '0;
        cnt_d   = CNT_INIT;
        state_d = DIV_R;
      end
      DIV_R, DIV_B: begin
        rem_d  = rem_ge_s ? rem_sub_s : rem_q;
        quot_d = quot_next_s;
        dsh_d  = dsh_q >> 1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          if (state_q == DIV_R) begin
            r_res_d = clamp_gain(zero_q, ovf_q, quot_next_s);
            rem_d   = n_q;
            dsh_d   = W'(b_snap_q) << (DIV_BITS - 1);
            ovf_d   = n_q >= (W'(b_snap_q) << DIV_BITS);
            zero_d  = (b_snap_q == '0);
            quot_d  = '0;
            cnt_d   = CNT_INIT;
            state_d = DIV_B;
          end else begin
            b_res_d = clamp_gain(zero_q, ovf_q, quot_next_s);
            state_d = UPDATE;
          end
        end else begin
          state_d = state_q;
        end
      end
      UPDATE: begin
        if (bus.awb_en) begin
          r_gain_d     = r_res_q;
          b_gain_d     = b_res_q;
          gain_valid_d = 1'b1;
        end else begin
          gain_valid_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      h_cnt_q      <= 11'd0;
      v_cnt_q      <= 11'd0;
      r_sum_q      <= '0;
      g_sum_q      <= '0;
      b_sum_q      <= '0;
      r_snap_q     <= '0;
      g_snap_q     <= '0;
      b_snap_q     <= '0;
      n_q          <= '0;
      rem_q        <= '0;
      dsh_q        <= '0;
      quot_q       <= '0;
      cnt_q        <= 4'd0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      r_res_q      <= 8'h80;
      b_res_q      <= 8'h80;
      r_gain_q     <= 8'h80;
      b_gain_q     <= 8'h80;
      gain_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      r_sum_q      <= r_sum_d;
      g_sum_q      <= g_sum_d;
      b_sum_q      <= b_sum_d;
      r_snap_q     <= r_snap_d;
      g_snap_q     <= g_snap_d;
      b_snap_q     <= b_snap_d;
      n_q          <= n_d;
      rem_q        <= rem_d;
      dsh_q        <= dsh_d;
      quot_q       <= quot_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      r_res_q      <= r_res_d;
      b_res_q      <= b_res_d;
      r_gain_q     <= r_gain_d;
      b_gain_q     <= b_gain_d;
      gain_valid_q <= gain_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.r_gain_out = r_gain_q;
  assign bus.g_gain_out = 8'h80;
  assign bus.b_gain_out = b_gain_q;
  assign bus.gain_valid = gain_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_awb_gain_est.sv
// Directed bench for awb_gain_est: a table of whole frames with hand-computed
// gains, plus sequences for frame-end-while-busy and reset mid-division.
module tb_awb_gain_est;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  awb_gain_est_if bus();

  awb_gain_est dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    int         h;
    int         v;
    int         rv;
    int         gv;
    int         bv;
    bit         en;
    bit         gaps;
    int         er;
    int         eb;
    int         epulses;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Bayer site value: start 0100 is R G / G B, everything else G B / R G.
  function automatic logic [7:0] pix(input logic [3:0] st, input int x, input int y,
                                     input int rv, input int gv, input int bv);
    logic [1:0] site;
    int v;
    site = {y[0], x[0]};
    if (st == 4'b0100) begin
      case (site)
        2'b00:   v = rv;
        2'b11:   v = bv;
        default: v = gv;
      endcase
    end else begin
      case (site)
        2'b01:   v = bv;
        2'b10:   v = rv;
        default: v = gv;
      endcase
    end
    return 8'(v);
  endfunction

  // Drives one frame; returns #1 after the edge that accepts the last pixel.
  task automatic drive_frame(input logic [3:0] st, input int h, input int v,
                             input int rv, input int gv, input int bv, input bit gaps);
    for (int y = 0; y < v; y++) begin
      for (int x = 0; x < h; x++) begin
        if (gaps && ((x + y) % 3 == 1)) begin
          @(negedge clk);
          bus.clken = 1'b0;
        end
        @(negedge clk);
        bus.bayer_state_start = st;
        bus.h_active_in       = 11'(h);
        bus.v_active_in       = 11'(v);
        bus.din               = pix(st, x, y, rv, gv, bv);
        bus.clken             = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.clken = 1'b0;
  endtask

  task automatic watch(input int n, output int pulses, output int first_k, output int busy1);
    pulses  = 0;
    first_k = -1;
    busy1   = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy1 = int'(bus.busy);
      if (bus.gain_valid) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  initial begin
    int pulses, first_k, busy1;
    n_total = 0;
    n_pass  = 0;

    //          st       h  v  rv   gv   bv   en gaps er     eb     pulses
    vecs[0] = '{4'b0001, 4, 4, 100, 100, 100, 1, 0, 'h80, 'h80, 1};
    vecs[1] = '{4'b0001, 4, 4, 50,  100, 200, 1, 0, 'hFF, 'h40, 1};
    vecs[2] = '{4'b0001, 4, 4, 100, 100, 100, 0, 0, 'hFF, 'h40, 0};
    vecs[3] = '{4'b0100, 4, 2, 64,  128, 128, 1, 0, 'hFF, 'h80, 1};
    vecs[4] = '{4'b0001, 4, 4, 0,   100, 100, 1, 0, 'h80, 'h80, 1};
    vecs[5] = '{4'b0001, 4, 4, 100, 50,  25,  1, 1, 'h40, 'hFF, 1};
    vecs[6] = '{4'b0011, 2, 2, 50,  100, 200, 1, 0, 'hFF, 'h40, 1};

    rst                   = 1'b1;
    bus.clken             = 1'b0;
    bus.din               = 8'd0;
    bus.bayer_state_start = 4'b0001;
    bus.h_active_in       = 11'd4;
    bus.v_active_in       = 11'd4;
    bus.awb_en            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_r_gain", int'(bus.r_gain_out), 'h80);
    check("reset_g_gain", int'(bus.g_gain_out), 'h80);
    check("reset_b_gain", int'(bus.b_gain_out), 'h80);
    check("reset_gain_valid", int'(bus.gain_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.awb_en = vecs[i].en;
      drive_frame(vecs[i].st, vecs[i].h, vecs[i].v, vecs[i].rv, vecs[i].gv,
                  vecs[i].bv, vecs[i].gaps);
      watch(30, pulses, first_k, busy1);
      check($sformatf("v%0d_busy_after_end", i), busy1, 1);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].epulses);
      check($sformatf("v%0d_pulse_edge", i), first_k, (vecs[i].epulses == 1) ? 20 : -1);
      check($sformatf("v%0d_r_gain", i), int'(bus.r_gain_out), vecs[i].er);
      check($sformatf("v%0d_g_gain", i), int'(bus.g_gain_out), 'h80);
      check($sformatf("v%0d_b_gain", i), int'(bus.b_gain_out), vecs[i].eb);
      check($sformatf("v%0d_busy_idle", i), int'(bus.busy), 0);
    end

    // Frame B ends 16 edges after frame A, while A is still dividing.
    bus.awb_en = 1'b1;
    drive_frame(4'b0001, 4, 4, 100, 100, 100, 1'b0);
    drive_frame(4'b0001, 4, 4, 50, 100, 200, 1'b0);
    watch(40, pulses, first_k, busy1);
    check("drop_pulses", pulses, 1);
    check("drop_pulse_edge", first_k, 4);
    check("drop_r_gain", int'(bus.r_gain_out), 'h80);
    check("drop_b_gain", int'(bus.b_gain_out), 'h80);

    // The sums restarted at B's end, so a clean frame C must give its own ratio.
    drive_frame(4'b0001, 4, 4, 50, 100, 200, 1'b0);
    watch(30, pulses, first_k, busy1);
    check("after_drop_pulse_edge", first_k, 20);
    check("after_drop_r_gain", int'(bus.r_gain_out), 'hFF);
    check("after_drop_b_gain", int'(bus.b_gain_out), 'h40);

    // Reset five cycles into DIV_R.
    drive_frame(4'b0001, 4, 4, 100, 100, 100, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("mid_reset_r_gain", int'(bus.r_gain_out), 'h80);
    check("mid_reset_b_gain", int'(bus.b_gain_out), 'h80);
    check("mid_reset_busy", int'(bus.busy), 0);
    check("mid_reset_gain_valid", int'(bus.gain_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    watch(30, pulses, first_k, busy1);
    check("post_reset_no_pulse", pulses, 0);
    check("post_reset_busy", int'(bus.busy), 0);

    drive_frame(4'b0001, 4, 4, 100, 100, 100, 1'b0);
    watch(30, pulses, first_k, busy1);
    check("recover_pulses", pulses, 1);
    check("recover_pulse_edge", first_k, 20);
    check("recover_r_gain", int'(bus.r_gain_out), 'h80);
    check("recover_b_gain", int'(bus.b_gain_out), 'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
